// File: rtl/bayer_demosaic_pkg.sv
// Shared definitions for the Bayer demosaic stage.
// Holds the pipeline dtype codes (as macros, so port declarations can
// use `DTYPE_WIDTH) plus package-scoped copies, the CFA phase
// constants and a helper that classifies pixel beats.
`ifndef BAYER_DEMOSAIC_DTYPES
`define BAYER_DEMOSAIC_DTYPES
`define DTYPE_WIDTH       4
`define DTYPE_FRAME_START 4'h1
`define DTYPE_FRAME_END   4'h2
`define DTYPE_ROW_START   4'h3
`define DTYPE_ROW_END     4'h4
`define DTYPE_HEADER      4'h5
`define DTYPE_PIXEL       4'h8
`define DTYPE_PIXEL_MASK  4'h8
`endif

package bayer_demosaic_pkg;

    localparam int DTYPE_W = `DTYPE_WIDTH;

    localparam logic [DTYPE_W-1:0] DTYPE_FRAME_START = `DTYPE_FRAME_START;
    localparam logic [DTYPE_W-1:0] DTYPE_FRAME_END   = `DTYPE_FRAME_END;
    localparam logic [DTYPE_W-1:0] DTYPE_ROW_START   = `DTYPE_ROW_START;
    localparam logic [DTYPE_W-1:0] DTYPE_ROW_END     = `DTYPE_ROW_END;
    localparam logic [DTYPE_W-1:0] DTYPE_HEADER      = `DTYPE_HEADER;
    localparam logic [DTYPE_W-1:0] DTYPE_PIXEL       = `DTYPE_PIXEL;
    localparam logic [DTYPE_W-1:0] DTYPE_PIXEL_MASK  = `DTYPE_PIXEL_MASK;

    // CFA colour at the kernel centre. Bit 0 = column position,
    // bit 1 = row position, so XOR with {row,col} parity walks the mosaic.
    localparam logic [1:0] BAYER_R  = 2'd0;
    localparam logic [1:0] BAYER_GR = 2'd1;
    localparam logic [1:0] BAYER_GB = 2'd2;
    localparam logic [1:0] BAYER_B  = 2'd3;

    function automatic logic is_pixel(input logic [DTYPE_W-1:0] dt);
        return |(dt & DTYPE_PIXEL_MASK);
    endfunction

endpackage

// File: rtl/bayer_demosaic_if.sv
// Stream bundle between the kernel stage, the demosaic stage and the
// downstream consumer.
//   bayer_phase/bypass : frame-level configuration (sampled on FRAME_START)
//   dvi/dtypei/meta_datai/kerneli : input beat
//   dvo/dtypeo/meta_datao/rgbo   : output beat, {R,G,B} with R in MSBs
// Handshake: a beat transfers on every clock where its valid is high;
// there is no ready/backpressure, so a consumer must accept every beat.
interface bayer_demosaic_if #(
    parameter int PIXEL_WIDTH = 10,
    parameter int DATA_WIDTH  = 16
);
    logic [1:0]               bayer_phase;
    logic                     bypass;
    logic                     dvi;
    logic [`DTYPE_WIDTH-1:0]  dtypei;
    logic [DATA_WIDTH-1:0]    meta_datai;
    logic [9*PIXEL_WIDTH-1:0] kerneli;
    logic                     dvo;
    logic [`DTYPE_WIDTH-1:0]  dtypeo;
    logic [DATA_WIDTH-1:0]    meta_datao;
    logic [3*PIXEL_WIDTH-1:0] rgbo;

    modport master (
        output bayer_phase, bypass, dvi, dtypei, meta_datai, kerneli,
        input  dvo, dtypeo, meta_datao, rgbo
    );

    modport slave (
        input  bayer_phase, bypass, dvi, dtypei, meta_datai, kerneli,
        output dvo, dtypeo, meta_datao, rgbo
    );
endinterface

// File: rtl/bayer_demosaic_interp.sv
// Bilinear demosaic datapath (two register stages).
//   Stage 1: neighbourhood sums plus centre, phase, bypass and pixel flag.
//   Stage 2: per-phase channel selection, truncating averages.
// Ports: clk, reset (sync, active-high), pix_i (beat is a valid pixel),
// kernel_i (packed 3x3, [r][c] at (r*3+c)*PIXEL_WIDTH), phase_i
// (effective CFA phase), bypass_i, rgb_o ({R,G,B}, zero for non-pixels).
module bayer_demosaic_interp
    import bayer_demosaic_pkg::*;
#(
    parameter int PIXEL_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pix_i,
    input  logic [9*PIXEL_WIDTH-1:0] kernel_i,
    input  logic [1:0]               phase_i,
    input  logic                     bypass_i,
    output logic [3*PIXEL_WIDTH-1:0] rgb_o
);
    localparam int PW = PIXEL_WIDTH;

    logic [PW-1:0] k [9];

    logic [PW+1:0] cross_d, cross_q, diag_d, diag_q;
    logic [PW:0]   horiz_d, horiz_q, vert_d, vert_q;
    logic [PW-1:0] centre_d, centre_q;
    logic [1:0]    phase_d, phase_q;
    logic          bypass_d, bypass_q, pix_d, pix_q;
    logic [3*PW-1:0] rgb_d, rgb_q;

    logic [PW-1:0] cross_avg, diag_avg, horiz_avg, vert_avg;
    logic [PW-1:0] r_ch, g_ch, b_ch;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            k[i] = kernel_i[i*PW +: PW];
        end
        // Indices: 0..2 top row, 3..5 middle row, 6..8 bottom row.
        cross_d  = {2'b00, k[1]} + {2'b00, k[3]} + {2'b00, k[5]} + {2'b00, k[7]};
        diag_d   = {2'b00, k[0]} + {2'b00, k[2]} + {2'b00, k[6]} + {2'b00, k[8]};
        horiz_d  = {1'b0, k[3]} + {1'b0, k[5]};
        vert_d   = {1'b0, k[1]} + {1'b0, k[7]};
        centre_d = k[4];
        phase_d  = phase_i;
        bypass_d = bypass_i;
        pix_d    = pix_i;
    end

    always_comb begin
        // Averages of N equal-width terms cannot exceed one pixel's range.
        cross_avg = cross_q[PW+1:2];
        diag_avg  = diag_q[PW+1:2];
        horiz_avg = horiz_q[PW:1];
        vert_avg  = vert_q[PW:1];
        r_ch = centre_q;
        g_ch = centre_q;
        b_ch = centre_q;
        if (!bypass_q) begin
            case (phase_q)
                BAYER_R:  begin r_ch = centre_q;  g_ch = cross_avg; b_ch = diag_avg;  end
                BAYER_GR: begin r_ch = horiz_avg; g_ch = centre_q;  b_ch = vert_avg;  end
                BAYER_GB: begin r_ch = vert_avg;  g_ch = centre_q;  b_ch = horiz_avg; end
                default:  begin r_ch = diag_avg;  g_ch = cross_avg; b_ch = centre_q;  end
            endcase
        end
        rgb_d = pix_q ? {r_ch, g_ch, b_ch} : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cross_q  <= '0;
            diag_q   <= '0;
            horiz_q  <= '0;
            vert_q   <= '0;
            centre_q <= '0;
            phase_q  <= '0;
            bypass_q <= 1'b0;
            pix_q    <= 1'b0;
            rgb_q    <= '0;
        end else begin
            cross_q  <= cross_d;
            diag_q   <= diag_d;
            horiz_q  <= horiz_d;
            vert_q   <= vert_d;
            centre_q <= centre_d;
            phase_q  <= phase_d;
            bypass_q <= bypass_d;
            pix_q    <= pix_d;
            rgb_q    <= rgb_d;
        end
    end

    assign rgb_o = rgb_q;
endmodule

// File: rtl/bayer_demosaic.sv
// Bayer demosaic stage: turns each 3x3 raw kernel into one RGB pixel and
// passes header/meta/framing beats through with the same 2-cycle latency.
// Ports: clk, reset (sync, active-high), bus (bayer_demosaic_if.slave).
// Frame configuration (bayer_phase, bypass) is latched on FRAME_START;
// row/column parity track the mosaic position within the frame.
module bayer_demosaic
    import bayer_demosaic_pkg::*;
#(
    parameter int PIXEL_WIDTH = 10,
    parameter int DATA_WIDTH  = 16
) (
    input  logic             clk,
    input  logic             reset,
    bayer_demosaic_if.slave  bus
);
    logic [1:0]            phase_d, phase_q;
    logic                  bypass_d, bypass_q;
    logic                  row_par_d, row_par_q;
    logic                  col_par_d, col_par_q;
    logic                  dv1_d, dv1_q, dv2_q;
    logic [DTYPE_W-1:0]    dtype1_d, dtype1_q, dtype2_q;
    logic [DATA_WIDTH-1:0] meta1_d, meta1_q, meta2_q;
    logic [1:0]            eff_phase;
    logic                  pix;

    always_comb begin
        phase_d   = phase_q;
        bypass_d  = bypass_q;
        row_par_d = row_par_q;
        col_par_d = col_par_q;
        // Phase used by this beat is based on parity before its own update.
        eff_phase = phase_q ^ {row_par_q, col_par_q};
        pix       = bus.dvi && is_pixel(bus.dtypei);
        if (bus.dvi) begin
            if (bus.dtypei == DTYPE_FRAME_START) begin
                phase_d   = bus.bayer_phase;
                bypass_d  = bus.bypass;
                row_par_d = 1'b0;
            end
            if (bus.dtypei == DTYPE_ROW_START) col_par_d = 1'b0;
            if (bus.dtypei == DTYPE_ROW_END)   row_par_d = ~row_par_q;
            if (pix)                           col_par_d = ~col_par_q;
        end
        dv1_d    = bus.dvi;
        dtype1_d = bus.dtypei;
        meta1_d  = bus.meta_datai;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= '0;
            bypass_q  <= 1'b0;
            row_par_q <= 1'b0;
            col_par_q <= 1'b0;
            dv1_q     <= 1'b0;
            dv2_q     <= 1'b0;
            dtype1_q  <= '0;
            dtype2_q  <= '0;
            meta1_q   <= '0;
            meta2_q   <= '0;
        end else begin
            phase_q   <= phase_d;
            bypass_q  <= bypass_d;
            row_par_q <= row_par_d;
            col_par_q <= col_par_d;
            dv1_q     <= dv1_d;
            dv2_q     <= dv1_q;
            dtype1_q  <= dtype1_d;
            dtype2_q  <= dtype1_q;
            meta1_q   <= meta1_d;
            meta2_q   <= meta1_q;
        end
    end

    bayer_demosaic_interp #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_interp (
        .clk      (clk),
        .reset    (reset),
        .pix_i    (pix),
        .kernel_i (bus.kerneli),
        .phase_i  (eff_phase),
        .bypass_i (bypass_q),
        .rgb_o    (bus.rgbo)
    );

    assign bus.dvo        = dv2_q;
    assign bus.dtypeo     = dtype2_q;
    assign bus.meta_datao = meta2_q;
endmodule

// File: tb/tb_bayer_demosaic.sv
// Directed bench for bayer_demosaic: each beat carries a hand-computed
// expectation that is compared when the beat leaves the pipeline.
module tb_bayer_demosaic;
  import bayer_demosaic_pkg::*;

  localparam int PW = 10;
  localparam int DW = 16;
  localparam int EW = 1 + DTYPE_W + DW + 3 * PW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bayer_demosaic_if #(.PIXEL_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

  bayer_demosaic #(.PIXEL_WIDTH(PW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] meta_cnt = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9*PW-1:0] kern(input int nw, input int n, input int ne,
                                           input int w, input int c, input int e,
                                           input int sw, input int s, input int se);
    logic [9*PW-1:0] k;
    k = {PW'(se), PW'(s), PW'(sw), PW'(e), PW'(c), PW'(w), PW'(ne), PW'(n), PW'(nw)};
    return k;
  endfunction

  function automatic logic [3*PW-1:0] rgbv(input int r, input int g, input int b);
    return {PW'(r), PW'(g), PW'(b)};
  endfunction

  // ---------------- driver ----------------
  // One beat per call; outputs seen after the edge belong to the previous call.
  task automatic send(input string tag, input logic dv, input logic [DTYPE_W-1:0] dt,
                      input logic [9*PW-1:0] k, input logic [3*PW-1:0] exp_rgb);
    logic [EW-1:0] e;
    bus.dvi        = dv;
    bus.dtypei     = dt;
    bus.meta_datai = meta_cnt;
    bus.kerneli    = k;
    exp_q.push_back({dv, dt, meta_cnt, exp_rgb});
    meta_cnt = meta_cnt + 1'b1;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val({tag, " dvo"},   32'(bus.dvo),        32'(e[EW-1]));
    check_val({tag, " dtype"}, 32'(bus.dtypeo),     32'(e[EW-2 -: DTYPE_W]));
    check_val({tag, " meta"},  32'(bus.meta_datao), 32'(e[3*PW+DW-1 -: DW]));
    check_val({tag, " rgb"},   32'(bus.rgbo),       32'(e[3*PW-1:0]));
  endtask

  task automatic ctl(input string tag, input logic [DTYPE_W-1:0] dt);
    send(tag, 1'b1, dt, kern(7, 7, 7, 7, 7, 7, 7, 7, 7), '0);
  endtask

  task automatic pix(input string tag, input logic [9*PW-1:0] k, input logic [3*PW-1:0] exp_rgb);
    send(tag, 1'b1, DTYPE_PIXEL, k, exp_rgb);
  endtask

  // ---------------- stimulus ----------------
  logic [9*PW-1:0] k_flat, k1, k2, k_t, k_max;

  initial begin
    k_flat = kern(100, 100, 100, 100, 100, 100, 100, 100, 100);
    k1     = kern(40, 200, 60, 200, 400, 200, 80, 200, 100);
    k2     = kern(40, 100, 60, 50, 400, 150, 80, 300, 100);
    k_t    = kern(0, 1, 0, 1, 5, 1, 0, 2, 0);
    k_max  = kern(1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023);

    reset           = 1'b1;
    bus.bayer_phase = 2'd0;
    bus.bypass      = 1'b0;
    bus.dvi         = 1'b1;
    bus.dtypei      = DTYPE_PIXEL;
    bus.meta_datai  = 16'h5555;
    bus.kerneli     = k_flat;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset dvo",   32'(bus.dvo), 32'd0);
    check_val("reset dtype", 32'(bus.dtypeo), 32'd0);
    check_val("reset meta",  32'(bus.meta_datao), 32'd0);
    check_val("reset rgb",   32'(bus.rgbo), 32'd0);
    reset = 1'b0;
    exp_q.push_back('0);
    bus.dvi = 1'b0; bus.dtypei = '0; bus.meta_datai = '0;
    meta_cnt = '0;

    // Flat field
    ctl("flat fs", DTYPE_FRAME_START);
    ctl("flat rs", DTYPE_ROW_START);
    for (int i = 0; i < 4; i++) pix("flat px", k_flat, rgbv(100, 100, 100));
    ctl("flat re", DTYPE_ROW_END);
    ctl("flat fe", DTYPE_FRAME_END);

    // R centre then Gr with the same kernel
    ctl("rc fs", DTYPE_FRAME_START);
    ctl("rc rs", DTYPE_ROW_START);
    pix("rc r",  k1, rgbv(400, 200, 70));
    pix("rc gr", k1, rgbv(200, 400, 200));
    ctl("rc re", DTYPE_ROW_END);
    ctl("rc fe", DTYPE_FRAME_END);

    // Parity walk over two rows, with a bubble inside the first row
    ctl("walk fs", DTYPE_FRAME_START);
    ctl("walk rs0", DTYPE_ROW_START);
    pix("walk r0",  k2, rgbv(400, 150, 70));
    send("walk bubble", 1'b0, '0, k2, '0);
    pix("walk gr0", k2, rgbv(100, 400, 200));
    pix("walk r1",  k2, rgbv(400, 150, 70));
    pix("walk gr1", k2, rgbv(100, 400, 200));
    ctl("walk re0", DTYPE_ROW_END);
    ctl("walk rs1", DTYPE_ROW_START);
    pix("walk gb0", k2, rgbv(200, 400, 100));
    pix("walk b0",  k2, rgbv(70, 150, 400));
    pix("walk gb1", k2, rgbv(200, 400, 100));
    pix("walk b1",  k2, rgbv(70, 150, 400));
    ctl("walk re1", DTYPE_ROW_END);
    ctl("walk fe", DTYPE_FRAME_END);

    // Truncation and maximum value
    ctl("trunc fs", DTYPE_FRAME_START);
    ctl("trunc rs", DTYPE_ROW_START);
    pix("trunc r", k_t, rgbv(5, 1, 0));
    pix("max gr",  k_max, rgbv(1023, 1023, 1023));
    ctl("trunc re", DTYPE_ROW_END);
    ctl("trunc fe", DTYPE_FRAME_END);

    // Mid-frame configuration change is ignored until the next frame
    ctl("mid fs", DTYPE_FRAME_START);
    ctl("mid rs", DTYPE_ROW_START);
    pix("mid r", k2, rgbv(400, 150, 70));
    bus.bayer_phase = 2'd3;
    bus.bypass      = 1'b1;
    pix("mid gr", k2, rgbv(100, 400, 200));
    ctl("mid re", DTYPE_ROW_END);
    ctl("mid rs1", DTYPE_ROW_START);
    pix("mid gb", k2, rgbv(200, 400, 100));
    ctl("mid re1", DTYPE_ROW_END);
    ctl("mid fe", DTYPE_FRAME_END);
    ctl("byp fs", DTYPE_FRAME_START);
    ctl("byp rs", DTYPE_ROW_START);
    pix("byp px0", k2, rgbv(400, 400, 400));
    pix("byp px1", k_t, rgbv(5, 5, 5));
    ctl("byp re", DTYPE_ROW_END);
    ctl("byp fe", DTYPE_FRAME_END);
    bus.bypass = 1'b0;
    ctl("pb fs", DTYPE_FRAME_START);
    ctl("pb rs", DTYPE_ROW_START);
    pix("pb b", k2, rgbv(70, 150, 400));
    send("pb unknown", 1'b1, 4'h7, k2, '0);
    pix("pb gb", k2, rgbv(200, 400, 100));

    // Reset in the middle of a pixel burst
    bus.dvi = 1'b1; bus.dtypei = DTYPE_PIXEL; bus.kerneli = k2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst dvo", 32'(bus.dvo), 32'd0);
    check_val("midrst rgb", 32'(bus.rgbo), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
    bus.dvi = 1'b0; bus.dtypei = '0;
    // Phase register cleared, so this pixel is R despite bayer_phase=3
    pix("post rst r", k2, rgbv(400, 150, 70));
    meta_cnt = 16'hA5C0;
    ctl("hdr fs", DTYPE_FRAME_START);
    ctl("hdr h0", DTYPE_HEADER);
    ctl("hdr h1", DTYPE_HEADER);
    ctl("hdr rs", DTYPE_ROW_START);
    pix("hdr b", k2, rgbv(70, 150, 400));
    send("flush0", 1'b0, '0, '0, '0);
    send("flush1", 1'b0, '0, '0, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
